// File: rtl/spatz_pkg.sv
// Shared types for the Spatz issue path: decoder request/response, decoded request,
// plus the issue FSM state and the buffered instruction entry.
package spatz_pkg;

  localparam int unsigned ELEN         = 32;
  localparam int unsigned IssueIdWidth = 5;

  typedef enum logic [2:0] {
    OP_NONE,
    VADD,
    VSUB,
    VAND,
    VOR,
    VXOR
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [4:0]      vd;
    logic [4:0]      vs1;
    logic [4:0]      vs2;
    logic [ELEN-1:0] rs1;
    logic [ELEN-1:0] rs2;
  } spatz_req_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [ELEN-1:0] rs1;
    logic [ELEN-1:0] rs2;
  } decoder_req_t;

  typedef struct packed {
    spatz_req_t spatz_req;
    logic       instr_illegal;
  } decoder_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    REJECT
  } issue_state_e;

  typedef struct packed {
    logic [31:0]             instr;
    logic [ELEN-1:0]         rs1;
    logic [ELEN-1:0]         rs2;
    logic [IssueIdWidth-1:0] id;
  } issue_entry_t;

endpackage

// File: rtl/spatz_issue_fifo.sv
// Instruction buffer for the issue controller: power-of-two depth, synchronous active-high
// reset, full/empty derived from an extra pointer MSB.
module spatz_issue_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  T               mem_q [Depth];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spatz_issue_ctrl.sv
// Requester side of the Spatz decoder interface: buffers core issues, decodes one at a time,
// forwards legal requests and answers the core in order. SPATZ_ISSUE_PERF_EN adds counters.
module spatz_issue_ctrl
  import spatz_pkg::*;
#(
  parameter int unsigned IssueDepth = 4,
  parameter int unsigned IdWidth    = IssueIdWidth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [ELEN-1:0]    issue_rs1_i,
  input  logic [ELEN-1:0]    issue_rs2_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output decoder_req_t       decoder_req_o,
  output logic               decoder_req_valid_o,
  input  decoder_rsp_t       decoder_rsp_i,
  input  logic               decoder_rsp_valid_i,
  output spatz_req_t         spatz_req_o,
  output logic               spatz_req_valid_o,
  input  logic               spatz_req_ready_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_illegal_o,
  output logic [IdWidth-1:0] rsp_id_o
`ifdef SPATZ_ISSUE_PERF_EN
  ,
  output logic [31:0]        cnt_issued_o,
  output logic [31:0]        cnt_illegal_o
`endif
);

  issue_state_e       state_q, state_d;
  spatz_req_t         spatz_req_q, spatz_req_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic               req_done_q, req_done_d;
  logic               rsp_done_q, rsp_done_d;

  issue_entry_t push_entry, head;
  logic         full, empty, pop;

  assign push_entry = '{instr: issue_instr_i, rs1: issue_rs1_i, rs2: issue_rs2_i,
                        id: IssueIdWidth'(issue_id_i)};

  spatz_issue_fifo #(
    .Depth (IssueDepth),
    .T     (issue_entry_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue_valid_i & ~full),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign issue_ready_o = ~full;
  assign decoder_req_o = '{instr: head.instr, rs1: head.rs1, rs2: head.rs2};
  assign spatz_req_o   = spatz_req_q;
  assign rsp_id_o      = id_q;

  always_comb begin
    state_d             = state_q;
    spatz_req_d         = spatz_req_q;
    id_d                = id_q;
    req_done_d          = req_done_q;
    rsp_done_d          = rsp_done_q;
    pop                 = 1'b0;
    decoder_req_valid_o = 1'b0;
    spatz_req_valid_o   = 1'b0;
    rsp_valid_o         = 1'b0;
    rsp_illegal_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        decoder_req_valid_o = ~empty;
        if (!empty && decoder_rsp_valid_i) begin
          pop         = 1'b1;
          spatz_req_d = decoder_rsp_i.spatz_req;
          id_d        = IdWidth'(head.id);
          state_d     = decoder_rsp_i.instr_illegal ? REJECT : DISPATCH;
        end
      end
      REJECT: begin
        rsp_valid_o   = 1'b1;
        rsp_illegal_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      DISPATCH: begin
        // Request and response complete independently; leave once both are done.
        spatz_req_valid_o = ~req_done_q;
        rsp_valid_o       = ~rsp_done_q;
        req_done_d        = req_done_q | (spatz_req_valid_o & spatz_req_ready_i);
        rsp_done_d        = rsp_done_q | (rsp_valid_o & rsp_ready_i);
        if (req_done_d && rsp_done_d) begin
          state_d    = IDLE;
          req_done_d = 1'b0;
          rsp_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      spatz_req_q <= '0;
      id_q        <= '0;
      req_done_q  <= 1'b0;
      rsp_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      spatz_req_q <= spatz_req_d;
      id_q        <= id_d;
      req_done_q  <= req_done_d;
      rsp_done_q  <= rsp_done_d;
    end
  end

`ifdef SPATZ_ISSUE_PERF_EN
  logic [31:0] cnt_issued_q, cnt_illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_issued_q  <= '0;
      cnt_illegal_q <= '0;
    end else begin
      if (spatz_req_valid_o && spatz_req_ready_i) cnt_issued_q <= cnt_issued_q + 32'd1;
      if (state_q == REJECT && rsp_ready_i) cnt_illegal_q <= cnt_illegal_q + 32'd1;
    end
  end

  assign cnt_issued_o  = cnt_issued_q;
  assign cnt_illegal_o = cnt_illegal_q;
`endif

endmodule

// File: tb/tb_spatz_issue_ctrl.sv
// Bench for spatz_issue_ctrl with a combinational decoder stub and in-order scoreboards
// for responses and dispatched requests. SPATZ_ISSUE_PERF_EN enables the counter test.
module tb_spatz_issue_ctrl;
  import spatz_pkg::*;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         issue_valid, issue_ready_o;
  logic [31:0]  issue_instr;
  logic [31:0]  issue_rs1, issue_rs2;
  logic [4:0]   issue_id;
  decoder_req_t decoder_req_o;
  logic         decoder_req_valid_o;
  decoder_rsp_t decoder_rsp;
  logic         dec_en;
  spatz_req_t   spatz_req_o;
  logic         spatz_req_valid_o, spatz_ready;
  logic         rsp_valid_o, rsp_ready, rsp_illegal_o;
  logic [4:0]   rsp_id_o;
`ifdef SPATZ_ISSUE_PERF_EN
  logic [31:0]  cnt_issued_o, cnt_illegal_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [4:0]  rsp_id_q  [$];
  logic        rsp_ill_q [$];
  spatz_req_t  req_q     [$];

  always #5 clk = ~clk;

  spatz_issue_ctrl #(.IssueDepth(4), .IdWidth(5)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .issue_valid_i       (issue_valid),
    .issue_ready_o       (issue_ready_o),
    .issue_instr_i       (issue_instr),
    .issue_rs1_i         (issue_rs1),
    .issue_rs2_i         (issue_rs2),
    .issue_id_i          (issue_id),
    .decoder_req_o       (decoder_req_o),
    .decoder_req_valid_o (decoder_req_valid_o),
    .decoder_rsp_i       (decoder_rsp),
    .decoder_rsp_valid_i (dec_en),
    .spatz_req_o         (spatz_req_o),
    .spatz_req_valid_o   (spatz_req_valid_o),
    .spatz_req_ready_i   (spatz_ready),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready),
    .rsp_illegal_o       (rsp_illegal_o),
    .rsp_id_o            (rsp_id_o)
`ifdef SPATZ_ISSUE_PERF_EN
    ,
    .cnt_issued_o        (cnt_issued_o),
    .cnt_illegal_o       (cnt_illegal_o)
`endif
  );

  // Decoder stub: OPIVV (opcode 0x57, funct3 0) with a handful of funct6 codes is legal.
  function automatic decoder_rsp_t tb_decode(input decoder_req_t r);
    decoder_rsp_t d;
    d = '0;
    d.instr_illegal     = 1'b1;
    d.spatz_req.vd      = r.instr[11:7];
    d.spatz_req.vs1     = r.instr[19:15];
    d.spatz_req.vs2     = r.instr[24:20];
    d.spatz_req.rs1     = r.rs1;
    d.spatz_req.rs2     = r.rs2;
    if (r.instr[6:0] == 7'h57 && r.instr[14:12] == 3'b000) begin
      d.instr_illegal = 1'b0;
      case (r.instr[31:26])
        6'b000000: d.spatz_req.op = VADD;
        6'b000010: d.spatz_req.op = VSUB;
        6'b001001: d.spatz_req.op = VAND;
        6'b001010: d.spatz_req.op = VOR;
        6'b001011: d.spatz_req.op = VXOR;
        default:   d.instr_illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  always_comb decoder_rsp = tb_decode(decoder_req_o);

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic [4:0] vd,
                                     input logic [4:0] vs1, input logic [4:0] vs2);
    return {f6, 1'b1, vs2, vs1, 3'b000, vd, 7'h57};
  endfunction

  // Handshakes are observed at negedge; the TB changes readys only just after posedge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rsp_valid_o && rsp_ready) begin
        total++;
        if (rsp_id_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got id=%0d illegal=%b required none", rsp_id_o, rsp_illegal_o);
        end else begin
          logic [4:0] eid;
          logic       eill;
          eid  = rsp_id_q.pop_front();
          eill = rsp_ill_q.pop_front();
          if (rsp_id_o !== eid || rsp_illegal_o !== eill) begin
            bad++;
            $display("FAIL rsp_order got id=%0d illegal=%b required id=%0d illegal=%b",
                     rsp_id_o, rsp_illegal_o, eid, eill);
          end
        end
      end
      if (spatz_req_valid_o && spatz_ready) begin
        total++;
        if (req_q.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected got %h required none", spatz_req_o);
        end else begin
          spatz_req_t e;
          e = req_q.pop_front();
          if (spatz_req_o !== e) begin
            bad++;
            $display("FAIL req_payload got %h required %h", spatz_req_o, e);
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] instr, input logic [4:0] id, input logic [31:0] rs1);
    decoder_req_t dr;
    decoder_rsp_t dd;
    int n;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_id    = id;
    issue_rs1   = rs1;
    issue_rs2   = ~rs1;
    n = 0;
    while (!issue_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!issue_ready_o) begin
      bad++;
      $display("FAIL push_timeout id=%0d ready=%b required 1", id, issue_ready_o);
    end else begin
      dr = '{instr: instr, rs1: rs1, rs2: ~rs1};
      dd = tb_decode(dr);
      rsp_id_q.push_back(id);
      rsp_ill_q.push_back(dd.instr_illegal);
      if (!dd.instr_illegal) req_q.push_back(dd.spatz_req);
    end
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((rsp_id_q.size() != 0 || req_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rsp_id_q.size() != 0 || req_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending rsp=%0d req=%0d required 0 0", nm, rsp_id_q.size(), req_q.size());
    end
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1 rst_i = 1'b1;
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    rsp_id_q.delete();
    rsp_ill_q.delete();
    req_q.delete();
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    total++;
    if ({issue_ready_o, decoder_req_valid_o, spatz_req_valid_o, rsp_valid_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_valids got rdy/dec/req/rsp=%b required 1000",
               {issue_ready_o, decoder_req_valid_o, spatz_req_valid_o, rsp_valid_o});
    end
    total++;
    if (spatz_req_o !== '0 || rsp_id_o !== 5'd0 || rsp_illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs got req=%h id=%0d ill=%b required 0", spatz_req_o, rsp_id_o, rsp_illegal_o);
    end
  endtask

  task automatic test_legal;
    push(32'h0220_8057, 5'd3, 32'h0000_1234);
    @(negedge clk);
    total++;
    if (decoder_req_valid_o !== 1'b1 || spatz_req_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL legal_decode_cycle got dec=%b req=%b rsp=%b required 1 0 0",
               decoder_req_valid_o, spatz_req_valid_o, rsp_valid_o);
    end
    @(negedge clk);
    total++;
    if (spatz_req_valid_o !== 1'b1 || spatz_req_o.op !== VADD || spatz_req_o.vs1 !== 5'd1 ||
        spatz_req_o.vs2 !== 5'd2 || spatz_req_o.vd !== 5'd0) begin
      bad++;
      $display("FAIL legal_req got v=%b op=%0d vs1=%0d vs2=%0d vd=%0d required 1 %0d 1 2 0",
               spatz_req_valid_o, spatz_req_o.op, spatz_req_o.vs1, spatz_req_o.vs2, spatz_req_o.vd, VADD);
    end
    total++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 5'd3 || rsp_illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL legal_rsp got v=%b id=%0d ill=%b required 1 3 0", rsp_valid_o, rsp_id_o, rsp_illegal_o);
    end
    drain("legal");
  endtask

  task automatic test_illegal;
    push(32'h0000_0000, 5'd7, 32'h0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid_o !== 1'b1 || rsp_illegal_o !== 1'b1 || rsp_id_o !== 5'd7 || spatz_req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL illegal_rsp got v=%b ill=%b id=%0d req=%b required 1 1 7 0",
               rsp_valid_o, rsp_illegal_o, rsp_id_o, spatz_req_valid_o);
    end
    drain("illegal");
  endtask

  task automatic test_backpressure;
    logic [5:0] f6 [5] = '{6'd0, 6'd2, 6'd9, 6'd10, 6'd11};
    @(posedge clk);
    #1 spatz_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(mk(f6[i], 5'(i), 5'(i + 1), 5'(i + 2)), 5'(i), 32'hA0 + i);
    repeat (3) @(negedge clk);
    total++;
    if (issue_ready_o !== 1'b0 || spatz_req_valid_o !== 1'b1 || spatz_req_o.rs1 !== 32'hA0) begin
      bad++;
      $display("FAIL bp_full got rdy=%b req=%b rs1=%h required 0 1 a0",
               issue_ready_o, spatz_req_valid_o, spatz_req_o.rs1);
    end
    @(posedge clk);
    #1 spatz_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_rsp_stall;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    push(mk(6'd2, 5'd4, 5'd5, 5'd6), 5'd10, 32'h10);
    push(mk(6'd9, 5'd7, 5'd8, 5'd9), 5'd11, 32'h11);
    @(negedge clk);
    total++;
    if (spatz_req_valid_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_both got req=%b rsp=%b required 1 1", spatz_req_valid_o, rsp_valid_o);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (spatz_req_valid_o !== 1'b0 || rsp_valid_o !== 1'b1 || decoder_req_valid_o !== 1'b0 || rsp_id_o !== 5'd10) begin
        bad++;
        $display("FAIL stall_hold got req=%b rsp=%b dec=%b id=%0d required 0 1 0 10",
                 spatz_req_valid_o, rsp_valid_o, decoder_req_valid_o, rsp_id_o);
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (decoder_req_valid_o !== 1'b1 || decoder_req_o.instr !== mk(6'd9, 5'd7, 5'd8, 5'd9)) begin
      bad++;
      $display("FAIL stall_next_decode got dec=%b instr=%h required 1 %h",
               decoder_req_valid_o, decoder_req_o.instr, mk(6'd9, 5'd7, 5'd8, 5'd9));
    end
    drain("rsp_stall");
  endtask

  task automatic test_decode_stall;
    @(posedge clk);
    #1 dec_en = 1'b0;
    push(mk(6'd10, 5'd1, 5'd2, 5'd3), 5'd20, 32'h20);
    repeat (3) @(negedge clk);
    total++;
    if (decoder_req_valid_o !== 1'b1 || rsp_valid_o !== 1'b0 || spatz_req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL decode_retry got dec=%b rsp=%b req=%b required 1 0 0",
               decoder_req_valid_o, rsp_valid_o, spatz_req_valid_o);
    end
    @(posedge clk);
    #1 dec_en = 1'b1;
    drain("decode_stall");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ins;
      ins = (i % 3 == 2) ? 32'h0000_0013 :
            mk(6'd11, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
      push(ins, 5'(i + 12), $urandom);
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_dispatch;
    @(posedge clk);
    #1 spatz_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(6'd0, 5'(i), 5'(i), 5'(i)), 5'(i + 24), 32'h30 + i);
    @(negedge clk);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({issue_ready_o, decoder_req_valid_o, spatz_req_valid_o, rsp_valid_o} !== 4'b1000) begin
      bad++;
      $display("FAIL rst_dispatch got rdy/dec/req/rsp=%b required 1000",
               {issue_ready_o, decoder_req_valid_o, spatz_req_valid_o, rsp_valid_o});
    end
    rst_i = 1'b0;
    spatz_ready = 1'b1;
    rsp_id_q.delete();
    rsp_ill_q.delete();
    req_q.delete();
    repeat (5) begin
      @(negedge clk);
      total++;
      if (decoder_req_valid_o !== 1'b0 || spatz_req_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL rst_dropped got dec=%b req=%b rsp=%b required 0 0 0",
                 decoder_req_valid_o, spatz_req_valid_o, rsp_valid_o);
      end
    end
  endtask

`ifdef SPATZ_ISSUE_PERF_EN
  task automatic test_perf;
    do_reset;
    for (int i = 0; i < 12; i++) push((i < 10) ? mk(6'd0, 5'd1, 5'd2, 5'd3) : 32'h0, 5'(i), 32'(i));
    drain("perf");
    @(negedge clk);
    total++;
    if (cnt_issued_o !== 32'd10 || cnt_illegal_o !== 32'd2) begin
      bad++;
      $display("FAIL perf_counts got issued=%0d illegal=%0d required 10 2", cnt_issued_o, cnt_illegal_o);
    end
    dut.cnt_issued_q  = 32'hFFFF_FFFF;
    dut.cnt_illegal_q = 32'hFFFF_FFFF;
    push(mk(6'd0, 5'd1, 5'd2, 5'd3), 5'd1, 32'h1);
    push(32'h0, 5'd2, 32'h2);
    drain("perf_wrap");
    @(negedge clk);
    total++;
    if (cnt_issued_o !== 32'd0 || cnt_illegal_o !== 32'd0) begin
      bad++;
      $display("FAIL perf_wrap got issued=%h illegal=%h required 0 0", cnt_issued_o, cnt_illegal_o);
    end
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_id    = '0;
    dec_en      = 1'b1;
    spatz_ready = 1'b1;
    rsp_ready   = 1'b1;
    test_reset;
    test_legal;
    test_illegal;
    test_backpressure;
    test_rsp_stall;
    test_decode_stall;
    test_back_to_back;
    test_reset_dispatch;
`ifdef SPATZ_ISSUE_PERF_EN
    test_perf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t required completion", $time);
    $fatal(1);
  end

endmodule
